// File: rtl/poly_mult_pkg.sv
// -----------------------------------------------------------------------------
// poly_mult_pkg
//   Shared definitions for the polynomial-multiplier systolic array, its job
//   sequencer and their benches:
//     - default coefficient width / polynomial length
//     - sequencer state encoding (plain localparam constants so older tools
//       and hand-written waveform decoders keep working)
//     - POLY_COEF(vec, i, n): slice coefficient i (width n) out of a packed
//       vector, coefficient 0 in the least-significant bits
// -----------------------------------------------------------------------------
package poly_mult_pkg;

  localparam int POLY_N = 17;  // coefficient width (bits)
  localparam int POLY_D = 16;  // coefficients per operand

  localparam logic [1:0] S_CLR  = 2'd0;  // array held in clear
  localparam logic [1:0] S_IDLE = 2'd1;  // waiting for a job
  localparam logic [1:0] S_RUN  = 2'd2;  // array filling / draining
  localparam logic [1:0] S_DONE = 2'd3;  // product waiting for consumer

endpackage

`ifndef POLY_COEF
`define POLY_COEF(vec, i, n) vec[(n)*(i) +: (n)]
`endif

// File: rtl/poly_mult_ctrl_cnt.sv
// -----------------------------------------------------------------------------
// poly_mult_ctrl_cnt
//   Phase counter for the job sequencer. Loads zero whenever the sequencer
//   changes state, otherwise counts up while enabled. o_term flags that the
//   count has reached the terminal value of the current phase; the sequencer
//   always leaves the phase on that cycle, so the counter never wraps.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clr        load zero (state change this cycle)
//   i_en         count enable
//   i_term       terminal value for the current phase
//   o_term       count == i_term
// -----------------------------------------------------------------------------
module poly_mult_ctrl_cnt #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [CW-1:0] i_term,
  output logic          o_term
);

  logic [CW-1:0] r_cnt;

  // NOTE: state is updated with non-blocking assignments so every flop in
  // the design samples values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_term = (r_cnt == i_term);

endmodule

// File: rtl/poly_mult_sa_ctrl.sv
// -----------------------------------------------------------------------------
// poly_mult_sa_ctrl
//   Job sequencer for poly_mult_systolic_array (array instance is external).
//   Takes one operand pair per job, holds it on the array inputs, clears the
//   array for CLR_CYC cycles, lets it run LAT cycles, captures the product and
//   offers it to the consumer. Only one job is in flight at a time.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     job handshake, operands on in_a / in_b
//   out_valid/out_ready   result handshake, product on out_p
//   arr_rst               synchronous clear to the array (low only in RUN)
//   arr_horz / arr_vert   held operands to the array
//   arr_p                 product vector from the array
//   busy                  sequencer not in IDLE
//   perf_jobs/perf_stall  only with POLY_MULT_CTRL_PERF_EN defined: completed
//                         output handshakes and DONE cycles with out_ready low,
//                         both saturating
// Vectors pack coefficient i at [N*(i+1)-1 : N*i].
// -----------------------------------------------------------------------------
module poly_mult_sa_ctrl
  import poly_mult_pkg::*;
#(
  parameter int N       = POLY_N,
  parameter int D       = POLY_D,
  parameter int LAT     = 2 * D,
  parameter int CLR_CYC = 1,
  parameter int CW      = $clog2(LAT + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*D-1:0] in_a,
  input  logic [N*D-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*D-1:0] out_p,
  output logic           arr_rst,
  output logic [N*D-1:0] arr_horz,
  output logic [N*D-1:0] arr_vert,
  input  logic [N*D-1:0] arr_p,
  output logic           busy
`ifdef POLY_MULT_CTRL_PERF_EN
  ,
  output logic [31:0]    perf_jobs,
  output logic [31:0]    perf_stall
`endif
);

  localparam logic [CW-1:0] TERM_CLR = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] TERM_RUN = CW'(LAT - 1);

  logic [1:0]     r_state;
  logic [1:0]     w_next_state;
  logic           r_pending;   // CLR phase belongs to an accepted job
  logic [N*D-1:0] r_a;
  logic [N*D-1:0] r_b;
  logic [N*D-1:0] r_p;
  logic           w_accept;
  logic           w_out_hs;
  logic           w_term;
  logic [CW-1:0]  w_term_val;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_out_hs = out_ready && (r_state == S_DONE);
  assign w_term_val = (r_state == S_RUN) ? TERM_RUN : TERM_CLR;

  poly_mult_ctrl_cnt #(
    .CW (CW)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_next_state != r_state),
    .i_en   ((r_state == S_CLR) || (r_state == S_RUN)),
    .i_term (w_term_val),
    .o_term (w_term)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CLR:   if (w_term)    w_next_state = r_pending ? S_RUN : S_IDLE;
      S_IDLE:  if (w_accept)  w_next_state = S_CLR;
      S_RUN:   if (w_term)    w_next_state = S_DONE;
      S_DONE:  if (w_out_hs)  w_next_state = S_IDLE;
      default:                w_next_state = S_CLR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLR;
      r_pending <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_pending <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_pending <= 1'b0;
      end
    end
  end

  // NOTE: the wide operand/product registers are reset as well: the array
  // inputs and out_p must read zero after reset, and a dropped job must not
  // leave its operands on the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
    end else begin
      if (w_accept) begin
        r_a <= in_a;
        r_b <= in_b;
      end
      if ((r_state == S_RUN) && w_term) begin
        r_p <= arr_p;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign arr_rst   = (r_state != S_RUN);
  assign arr_horz  = r_a;
  assign arr_vert  = r_b;
  assign out_p     = r_p;

`ifdef POLY_MULT_CTRL_PERF_EN
  logic [31:0] r_jobs;
  logic [31:0] r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jobs  <= '0;
      r_stall <= '0;
    end else begin
      if (w_out_hs && (r_jobs != '1)) begin
        r_jobs <= r_jobs + 1'b1;
      end
      if ((r_state == S_DONE) && !out_ready && (r_stall != '1)) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  assign perf_jobs  = r_jobs;
  assign perf_stall = r_stall;
`else
  // Performance counters not built; the ports above are absent.
`endif

endmodule

// File: tb/tb_poly_mult_sa_ctrl.sv
// -----------------------------------------------------------------------------
// tb_poly_mult_sa_ctrl
//   Bench for the job sequencer. The systolic array is replaced by a timing
//   model: it shows the true product of its held operands only in the cycle
//   that ends LAT cycles after arr_rst falls, and the bitwise inverse of it in
//   every other cycle, so a capture on the wrong cycle returns a wrong vector.
//   Expected products come from a plain schoolbook polynomial product
//   (coefficients truncated to N bits, terms beyond degree D-1 dropped).
// -----------------------------------------------------------------------------
module tb_poly_mult_sa_ctrl;
  import poly_mult_pkg::*;

  localparam int N          = POLY_N;
  localparam int D          = POLY_D;
  localparam int W          = N * D;
  localparam int LAT        = 2 * D;
  localparam int CLR_CYC    = 1;
  localparam int JOB_LAT    = CLR_CYC + LAT + 1;  // accept edge -> out_valid cycle
  localparam int JOB_PERIOD = CLR_CYC + LAT + 2;  // accept-to-accept, out_ready high

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p;
  logic         arr_rst;
  logic [W-1:0] arr_horz;
  logic [W-1:0] arr_vert;
  logic [W-1:0] arr_p;
  logic         busy;
`ifdef POLY_MULT_CTRL_PERF_EN
  logic [31:0]  perf_jobs;
  logic [31:0]  perf_stall;
`endif

  poly_mult_sa_ctrl #(
    .N       (N),
    .D       (D),
    .LAT     (LAT),
    .CLR_CYC (CLR_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .arr_rst   (arr_rst),
    .arr_horz  (arr_horz),
    .arr_vert  (arr_vert),
    .arr_p     (arr_p),
    .busy      (busy)
`ifdef POLY_MULT_CTRL_PERF_EN
    ,
    .perf_jobs  (perf_jobs),
    .perf_stall (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] poly_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]    r;
    longint unsigned acc;
    r = '0;
    for (int k = 0; k < D; k++) begin
      acc = 0;
      for (int i = 0; i <= k; i++) begin
        acc += 64'(a[N*i +: N]) * 64'(b[N*(k-i) +: N]);
      end
      r[N*k +: N] = acc[N-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) v[N*i +: N] = N'($urandom);
    return v;
  endfunction

  // Array timing model: counts completed cycles with arr_rst low.
  int run_cyc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       run_cyc <= 0;
    else if (arr_rst) run_cyc <= 0;
    else              run_cyc <= run_cyc + 1;
  end
  always_comb begin
    arr_p = poly_mul(arr_horz, arr_vert);
    if (arr_rst || run_cyc != LAT - 1) arr_p = ~arr_p;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a job, wait (bounded) for the accept edge, then scramble the
  // inputs and confirm the array still sees the accepted operands.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    guard    = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", W'(in_ready), W'(1));
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = rand_vec();
    in_b     = rand_vec();
    check("hold_horz", arr_horz, a);
    check("hold_vert", arr_vert, b);
  endtask

  // Called right after the accept edge; returns the index of the cycle
  // (counted in edges from the accept edge) in which out_valid is first high.
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) check("out_timeout", W'(out_valid), W'(1));
  endtask

  task automatic take(input string tag, input logic [W-1:0] exp);
    check(tag, out_p, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", W'(out_valid), W'(0));
  endtask

  initial begin
    logic [W-1:0] a, b, exp_p;
    logic [W-1:0] exp_q[$];
    int           acc_t[$];
    int           lat, cyc, n_res;
    logic         seen, acc_now, hs_now;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;

    // Reset state and release
    repeat (3) @(negedge clk);
    check("rst_in_ready",  W'(in_ready),  W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_arr_rst",   W'(arr_rst),   W'(1));
    check("rst_out_p",     out_p,         '0);
    check("rst_arr_horz",  arr_horz,      '0);
    check("rst_busy",      W'(busy),      W'(1));
    rst_n = 1'b1;
    check("rel_in_ready0", W'(in_ready), W'(0));
    @(negedge clk);
    check("rel_in_ready1", W'(in_ready), W'(1));
    check("idle_busy",     W'(busy),     W'(0));
    check("idle_arr_rst",  W'(arr_rst),  W'(1));

    // Single job: a = 1, so the product is b itself
    a = '0;
    a[0] = 1'b1;
    for (int i = 0; i < D; i++) b[N*i +: N] = N'(i + 1);
    send(a, b);
    check("run_in_ready", W'(in_ready), W'(0));
    wait_out(lat);
    check("latency_unit", W'(lat), W'(JOB_LAT));
    take("unit_prod", b);

    // Random jobs
    repeat (4) begin
      a = rand_vec();
      b = rand_vec();
      send(a, b);
      wait_out(lat);
      check("latency_rand", W'(lat), W'(JOB_LAT));
      take("rand_prod", poly_mul(a, b));
    end

    // Backpressure in DONE with a competing job offered
    a = rand_vec();
    b = rand_vec();
    exp_p = poly_mul(a, b);
    send(a, b);
    wait_out(lat);
    in_valid = 1'b1;
    in_a     = rand_vec();
    in_b     = rand_vec();
    repeat (10) begin
      @(negedge clk);
      check("bp_valid",    W'(out_valid), W'(1));
      check("bp_out_p",    out_p,         exp_p);
      check("bp_in_ready", W'(in_ready),  W'(0));
      check("bp_horz",     arr_horz,      a);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_valid_drop", W'(out_valid), W'(0));
    check("bp_p_kept",     out_p,         exp_p);
    check("bp_back_idle",  W'(in_ready),  W'(1));
    check("bp_no_accept",  arr_horz,      a);

    // Back-to-back jobs with both handshakes held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = rand_vec();
    in_b      = rand_vec();
    cyc       = 0;
    n_res     = 0;
    while ((acc_t.size() < 3 || n_res < 3) && cyc < 400) begin
      acc_now = in_valid && in_ready;
      hs_now  = out_valid && out_ready;
      if (hs_now) begin
        if (exp_q.size() == 0) check("b2b_extra_result", W'(1), W'(0));
        else check("b2b_prod", out_p, exp_q.pop_front());
        n_res++;
      end
      if (acc_now) begin
        exp_q.push_back(poly_mul(in_a, in_b));
        acc_t.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
      if (acc_now) begin
        if (acc_t.size() < 3) begin
          in_a = rand_vec();
          in_b = rand_vec();
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b_results", W'(n_res), W'(3));
    if (acc_t.size() == 3) begin
      check("b2b_space1", W'(acc_t[1] - acc_t[0]), W'(JOB_PERIOD));
      check("b2b_space2", W'(acc_t[2] - acc_t[1]), W'(JOB_PERIOD));
    end else begin
      check("b2b_accepts", W'(acc_t.size()), W'(3));
    end

    // Reset in the middle of RUN (counter at 10)
    send(rand_vec(), rand_vec());
    repeat (CLR_CYC + 10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid", W'(out_valid), W'(0));
    check("mid_in_ready",  W'(in_ready),  W'(0));
    check("mid_arr_rst",   W'(arr_rst),   W'(1));
    check("mid_out_p",     out_p,         '0);
    check("mid_arr_horz",  arr_horz,      '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (JOB_PERIOD + 5) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_valid", W'(seen), W'(0));
    a = rand_vec();
    b = rand_vec();
    send(a, b);
    wait_out(lat);
    check("mid_latency", W'(lat), W'(JOB_LAT));
    take("mid_prod", poly_mul(a, b));

`ifdef POLY_MULT_CTRL_PERF_EN
    // Performance counters: 3 jobs, 5 stall cycles in total
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("perf_rst_jobs", W'(perf_jobs), W'(0));
    for (int j = 0; j < 3; j++) begin
      a = rand_vec();
      b = rand_vec();
      send(a, b);
      wait_out(lat);
      if (j == 1) repeat (5) @(negedge clk);
      take("perf_prod", poly_mul(a, b));
    end
    check("perf_jobs",  W'(perf_jobs),  W'(3));
    check("perf_stall", W'(perf_stall), W'(5));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
